// File: rtl/csa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_pkg : shared defaults, derived sizes and FSM state type        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package csa_pkg;

  localparam int CSA_DATA_LEN = 384;
  localparam int CSA_SEG_LEN  = 64;
  localparam int CSA_NUM_SEGS = CSA_DATA_LEN / CSA_SEG_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } csa_state_t;

endpackage
`default_nettype wire

// File: rtl/csa_resolver_seg_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | full_adder / seg_adder : SEG_LEN-bit ripple adder, carry in/out    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module seg_adder #(
  parameter int SEG_LEN = 64
) (
  input  logic [SEG_LEN-1:0] a,
  input  logic [SEG_LEN-1:0] b,
  input  logic               cin,
  output logic [SEG_LEN-1:0] sum,
  output logic               cout
);
  logic [SEG_LEN:0] w_c;

  assign w_c[0] = cin;
  assign cout   = w_c[SEG_LEN];

  for (genvar i = 0; i < SEG_LEN; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .sum  (sum[i]),
      .cout (w_c[i+1])
    );
  end
endmodule
`default_nettype wire

// File: rtl/csa_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_resolver : resolves a carry-save pair into binary S + 2*Cout,  |
// |                one segment per cycle through a shared seg_adder    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module csa_resolver
  import csa_pkg::*;
#(
  parameter int DATA_LEN = CSA_DATA_LEN,
  parameter int SEG_LEN  = CSA_SEG_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] S,
  input  logic [DATA_LEN-1:0] Cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN+1:0] result
);

  localparam int c_num_segs = DATA_LEN / SEG_LEN;
  localparam int c_cnt_w    = (c_num_segs > 1) ? $clog2(c_num_segs) : 1;
  localparam logic [c_cnt_w-1:0] c_last_seg = c_cnt_w'(c_num_segs - 1);

  csa_state_t          r_state;
  logic [c_cnt_w-1:0]  r_seg_cnt;
  logic                r_carry;
  logic                r_top;
  logic [SEG_LEN-1:0]  r_a   [c_num_segs];
  logic [SEG_LEN-1:0]  r_b   [c_num_segs];
  logic [SEG_LEN-1:0]  r_res [c_num_segs];
  logic [1:0]          r_res_top;

  logic [DATA_LEN-1:0] w_b_full;
  logic [SEG_LEN-1:0]  w_sum;
  logic                w_cout;
  logic                w_last;

  // Carry vector weights start at 2^1, so shift it into place once at capture.
  assign w_b_full  = {Cout[DATA_LEN-2:0], 1'b0};
  assign w_last    = (r_seg_cnt == c_last_seg);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  seg_adder #(
    .SEG_LEN (SEG_LEN)
  ) u_seg_adder (
    .a    (r_a[r_seg_cnt]),
    .b    (r_b[r_seg_cnt]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  for (genvar k = 0; k < c_num_segs; k++) begin : g_res
    assign result[k*SEG_LEN +: SEG_LEN] = r_res[k];
  end
  assign result[DATA_LEN+1:DATA_LEN] = r_res_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_seg_cnt <= '0;
      r_carry   <= 1'b0;
      r_top     <= 1'b0;
      r_res_top <= 2'b00;
      for (int k = 0; k < c_num_segs; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < c_num_segs; k++) begin
              r_a[k] <= S[k*SEG_LEN +: SEG_LEN];
              r_b[k] <= w_b_full[k*SEG_LEN +: SEG_LEN];
            end
            r_top     <= Cout[DATA_LEN-1];
            r_seg_cnt <= '0;
            r_carry   <= 1'b0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          r_res[r_seg_cnt] <= w_sum;
          r_carry          <= w_cout;
          if (w_last) begin
            // Final ripple carry and the dropped Cout MSB both land at 2^DATA_LEN.
            r_res_top <= {1'b0, w_cout} + {1'b0, r_top};
            r_state   <= DONE;
          end else begin
            r_seg_cnt <= r_seg_cnt + c_cnt_w'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_csa_resolver : directed self-checking bench for csa_resolver    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_csa_resolver;

  localparam int DL = 384;
  localparam int SL = 64;
  localparam int NS = DL / SL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DL-1:0] S = '0;
  logic [DL-1:0] Cout = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DL+1:0] result;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  csa_resolver #(
    .DATA_LEN (DL),
    .SEG_LEN  (SL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DL+1:0] model(input logic [DL-1:0] s, input logic [DL-1:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [DL+1:0] obs, input logic [DL+1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [DL-1:0] s, input logic [DL-1:0] c,
                        input logic [DL+1:0] exp, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    S = s;
    Cout = c;
    @(negedge clk);
    in_valid = 1'b0;
    S = {12{32'hDEADBEEF}};
    Cout = ~c;
    check({tag, ".in_ready_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, NS);
    check({tag, ".result"}, result, exp);
    repeat (hold) begin
      @(negedge clk);
      check({tag, ".hold_result"}, result, exp);
      check({tag, ".hold_in_ready"}, in_ready, 0);
      check({tag, ".hold_out_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".post_in_ready"}, in_ready, 1);
    check({tag, ".post_out_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [DL-1:0] bs [3];
    logic [DL-1:0] bc [3];
    logic [DL-1:0] ones;
    logic [DL+1:0] exp_max;
    int last_acc;
    int acc;
    int w;

    ones = '1;
    exp_max = {2'b10, {382{1'b1}}, 1'b0, 1'b1};

    // Reset state
    #2;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.result", result, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 384'd5, 384'd3, 386'd11, 0);
    run_op("xseg", {320'd0, {64{1'b1}}}, 384'd1, (386'd1 << 64) + 386'd1, 0);
    run_op("max", ones, ones, exp_max, 0);
    run_op("zero", 384'd0, 384'd0, 386'd0, 0);
    run_op("bp", {6{64'h0123456789ABCDEF}}, {6{64'hFEDCBA9876543210}},
           model({6{64'h0123456789ABCDEF}}, {6{64'hFEDCBA9876543210}}), 10);

    // Reset pulse in the third BUSY cycle
    @(negedge clk);
    in_valid = 1'b1;
    S = 384'd5;
    Cout = 384'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.in_ready", in_ready, 1);
    check("midrst.result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 384'd7, 384'd1, 386'd9, 0);

    // Back-to-back with in_valid held and out_ready tied high
    bs[0] = {6{64'hA5A5A5A5_5A5A5A5A}};
    bc[0] = {6{64'hFFFF0000_FFFF0000}};
    bs[1] = ones;
    bc[1] = 384'd1;
    bs[2] = {12{32'h13579BDF}};
    bc[2] = ones;
    out_ready = 1'b1;
    in_valid = 1'b1;
    last_acc = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      w = 0;
      while (!in_ready && w < 40) begin
        S = {12{32'hCAFEF00D}};
        Cout = {12{32'h0BADC0DE}};
        @(negedge clk);
        w++;
      end
      S = bs[i];
      Cout = bc[i];
      acc = cyc;
      if (i > 0) check($sformatf("b2b.spacing%0d", i), acc - last_acc, NS + 2);
      last_acc = acc;
      @(negedge clk);
      w = 0;
      while (!out_valid && w < 40) begin
        S = ~bs[i];
        Cout = ~bc[i];
        @(negedge clk);
        w++;
      end
      check($sformatf("b2b.result%0d", i), result, model(bs[i], bc[i]));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 SHALL have parameter DATA_LEN, default 384: width of each redundant input vector.
REQ-002 SHALL have parameter SEG_LEN, default 64: bits resolved per cycle; DATA_LEN SHALL be a multiple of SEG_LEN.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  redundant operand pair present.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 S  input  DATA_LEN  sum vector; bit i has weight 2^i.
REQ-008 Cout  input  DATA_LEN  carry vector; bit i has weight 2^(i+1).
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  DATA_LEN+2  binary value S + 2*Cout.

Function
REQ-012 The block SHALL be an FSM with three states: IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an input is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-014 On accept, the block SHALL register both operands:
- A = S
- B = {Cout[DATA_LEN-2:0], 1'b0}
- top = Cout[DATA_LEN-1]
It SHALL also clear seg_cnt and the segment carry, and enter BUSY.
REQ-015 Each BUSY cycle SHALL add segment seg_cnt of A and B plus the registered carry.
- The SEG_LEN-bit sum goes into the result register; the carry-out is registered.
- seg_cnt then increments.
REQ-016 On the edge completing segment NUM_SEGS-1, the block SHALL write result[DATA_LEN+1:DATA_LEN] = final carry + top and enter DONE.
REQ-017 out_valid SHALL be 1 exactly in DONE; the first cycle with out_valid=1 is NUM_SEGS cycles after the accepting edge.
REQ-018 In DONE, result SHALL hold stable while out_ready=0, without limit.
REQ-019 When out_valid=1 and out_ready=1, the block SHALL return to IDLE at that edge; in_ready is 1 in the following cycle.
REQ-020 in_valid and input data SHALL be ignored in BUSY and DONE; the captured operands SHALL NOT change.
REQ-021 result SHALL be exact modulo nothing: full DATA_LEN+2 bits, with no truncation at maximum inputs.
REQ-022 seg_cnt SHALL be $clog2(NUM_SEGS) bits wide (minimum 1) and SHALL NOT wrap during an operation.

Reset
REQ-023 While rst_n=0, the block SHALL immediately force:
- state to IDLE
- in_ready=1, out_valid=0
- result=0
- seg_cnt=0, carry=0
REQ-024 Reset asserted in BUSY or DONE SHALL abandon the operation; the first operation after release SHALL be correct and unaffected.

Structure
REQ-025 A shared package csa_pkg SHALL hold:
- the default DATA_LEN and SEG_LEN
- the derived NUM_SEGS = DATA_LEN/SEG_LEN
- the state enum typedef (IDLE, BUSY, DONE)
REQ-026 The segment addition SHALL be one sub-module, seg_adder: a SEG_LEN-bit ripple adder with carry-in and carry-out, built from full_adder cells.
REQ-027 The block SHALL contain exactly one seg_adder instance, time-multiplexed over the segments.

Verification
REQ-028 Basic resolve: S=5, Cout=3 -> result=11, with out_valid rising 6 cycles after accept (DATA_LEN=384, SEG_LEN=64).
REQ-029 Cross-segment carry: S=2^64-1, Cout=1 -> result=2^64+1.
REQ-030 Maximum inputs: S and Cout all ones -> result = 3*2^384-3.
- result[385:384]=2'b10
- result[383:0] = all ones except bit 1 = 0 (0xFF..FD)
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE, then raise it.
- result stays stable and in_ready stays 0 throughout.
- The block returns to IDLE on the handshake edge.
REQ-032 Reset mid-operation: pulse rst_n low in the 3rd BUSY cycle.
- Required: out_valid=0 and in_ready=1 immediately.
- Then S=7, Cout=1 -> result=9.
REQ-033 Back-to-back: hold in_valid=1 with out_ready=1 tied high.
- One accept every NUM_SEGS+2 cycles.
- All results match the reference model S+2*Cout.
